// File: rtl/sobel_stream_core_if.sv
// Stream bundle for the Sobel core: pixel input stream, edge output stream
// and the output-mode controls that travel alongside them.
interface sobel_stream_core_if #(
  parameter int PIX_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;
  logic             mode_thresh;
  logic [PIX_W-1:0] thresh;

  // Producer/consumer side (drives pixels, accepts edges)
  modport master (
    output s_valid, s_data, m_ready, mode_thresh, thresh,
    input  s_ready, m_valid, m_data, m_last
  );

  // Core side
  modport slave (
    input  s_valid, s_data, m_ready, mode_thresh, thresh,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sobel_stream_core.sv
// Streaming Sobel edge engine: two line buffers feed a 3x3 shift window,
// followed by a window register stage and a magnitude register stage.
// Every stage advances together under en so backpressure freezes the pipe.
module sobel_stream_core #(
  parameter int IMG_WIDTH  = 549,
  parameter int IMG_HEIGHT = 319,
  parameter int PIX_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  sobel_stream_core_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = PIX_W + 4;   // signed gradient width
  localparam int MW = PIX_W + 5;   // |Gx|+|Gy| without overflow
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [MW-1:0] SAT_MAX  = {{(MW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic             rdy_q, rdy_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             v0_q, v0_d, last0_q, last0_d;
  logic             v1_q, v1_d, last1_q, last1_d;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [PIX_W-1:0] m_data_q, m_data_d;

  logic [PIX_W-1:0] line_buf0 [IMG_WIDTH];   // row r-1
  logic [PIX_W-1:0] line_buf1 [IMG_WIDTH];   // row r-2
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [PIX_W-1:0] stg_q [3][3];
  logic [PIX_W-1:0] stg_d [3][3];

  logic             en, accept;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic signed [GW-1:0] px [3][3];
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay;
  logic [MW-1:0]        mag;
  logic [PIX_W-1:0]     mag_sat, pix_out;

  // The whole pipe moves whenever the output slot is free or being drained;
  // rdy_q keeps s_ready low until the first edge after reset release.
  assign en          = bus.m_ready || !m_valid_q;
  assign bus.s_ready = en && rdy_q;
  assign accept      = bus.s_valid && bus.s_ready;
  assign lb0_rd      = line_buf0[col_q];
  assign lb1_rd      = line_buf1[col_q];

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;

  // Raster counters, ready enable and shift-window next state
  always_comb begin
    rdy_d = 1'b1;
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = bus.s_data;
    end
  end

  // Pipeline valid/last/data next state; all stages hold when en is low
  always_comb begin
    v0_d      = v0_q;
    last0_d   = last0_q;
    v1_d      = v1_q;
    last1_d   = last1_q;
    stg_d     = stg_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (en) begin
      // Only interior centres are emitted: the accepted pixel must be at
      // least two rows and two columns into the frame.
      v0_d      = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      last0_d   = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
      v1_d      = v0_q;
      last1_d   = last0_q;
      stg_d     = win_q;
      m_valid_d = v1_q;
      m_last_d  = last1_q;
      if (v1_q) m_data_d = pix_out;
    end
  end

  // Zero-extend the staged window into signed gradient operands
  for (genvar gi = 0; gi < 9; gi++) begin : g_ext
    assign px[gi/3][gi%3] = $signed({4'b0000, stg_q[gi/3][gi%3]});
  end

  // Gradients, magnitude, saturation and optional threshold
  always_comb begin
    gx = (px[0][2] + (px[1][2] <<< 1) + px[2][2]) - (px[0][0] + (px[1][0] <<< 1) + px[2][0]);
    gy = (px[2][0] + (px[2][1] <<< 1) + px[2][2]) - (px[0][0] + (px[0][1] <<< 1) + px[0][2]);
    ax = gx[GW-1] ? -gx : gx;
    ay = gy[GW-1] ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};
    mag_sat = (mag > SAT_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
    pix_out = mag_sat;
    if (bus.mode_thresh) pix_out = (mag_sat >= bus.thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q     <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      v0_q      <= 1'b0;
      last0_q   <= 1'b0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      rdy_q     <= rdy_d;
      col_q     <= col_d;
      row_q     <= row_d;
      v0_q      <= v0_d;
      last0_q   <= last0_d;
      v1_q      <= v1_d;
      last1_q   <= last1_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  // Datapath storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf0[col_q] <= bus.s_data;
      line_buf1[col_q] <= lb0_rd;
    end
    win_q <= win_d;
    stg_q <= stg_d;
  end
endmodule

// File: tb/tb_sobel_stream_core.sv
// Scoreboard bench for sobel_stream_core on a 5x4 frame.
module tb_sobel_stream_core;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_stream_core_if #(.PIX_W(PW)) bus();

  sobel_stream_core #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         errors   = 0;
  int         out_cnt  = 0;
  int         last_cnt = 0;
  logic [7:0] img [H][W];
  bit         rand_rdy = 1'b0;
  int         gap_pct  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, req);
    end
  endtask

  // Reference Sobel for the window whose bottom-right pixel is (r,c)
  function automatic logic [7:0] model(input int r, input int c);
    int p [3][3];
    int gx, gy, mag;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(img[r-2+i][c-2+j]);
    gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    if (bus.mode_thresh) return (mag >= int'(bus.thresh)) ? 8'hFF : 8'h00;
    return 8'(mag);
  endfunction

  // Output-side backpressure
  always @(posedge clk) begin
    #1;
    bus.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: the head of the scoreboard must be presented (and held
  // while stalled) until the beat is taken.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.m_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        if (bus.m_ready) check("unexpected_out", 1, 0);
      end else begin
        if (bus.m_ready) begin
          check("m_data", bus.m_data, exp_q[0].data);
          check("m_last", bus.m_last, exp_q[0].last);
          $display("OUT #%0d data=%02h last=%0b", out_cnt, bus.m_data, bus.m_last);
          out_cnt++;
          if (bus.m_last) last_cnt++;
          void'(exp_q.pop_front());
        end else begin
          check("m_data_hold", bus.m_data, exp_q[0].data);
          check("m_last_hold", bus.m_last, exp_q[0].last);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_pixel(input int r, input int c);
    bit   ok;
    int   n;
    exp_t e;
    if (gap_pct > 0)
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        @(posedge clk);
        #1;
      end
    bus.s_valid = 1'b1;
    bus.s_data  = img[r][c];
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    else if (r >= 2 && c >= 2) begin
      e.data = model(r, c);
      e.last = (r == H-1) && (c == W-1);
      exp_q.push_back(e);
    end
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pixel(r, c);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag, input int outs, input int lasts);
    check({tag, "_outs"}, out_cnt, outs);
    check({tag, "_lasts"}, last_cnt, lasts);
    out_cnt  = 0;
    last_cnt = 0;
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = v;
  endtask

  task automatic fill_step();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (c >= 3) ? 8'hFF : 8'h00;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'(c * 10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.mode_thresh = 1'b0;
    bus.thresh      = '0;
    bus.m_ready     = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data",  bus.m_data, 0);
    check("rst_m_last",  bus.m_last, 0);
    check("rst_s_ready", bus.s_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_s_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;

    // 1: constant image
    fill_const(8'h80);
    send_frame();
    drain();
    check_counts("const", 6, 1);

    // 2: vertical step
    fill_step();
    send_frame();
    drain();
    check_counts("step", 6, 1);

    // 3: ramp, magnitude then threshold at and just above the magnitude
    fill_ramp();
    send_frame();
    drain();
    check_counts("ramp", 6, 1);
    bus.mode_thresh = 1'b1;
    bus.thresh      = 8'h50;
    send_frame();
    drain();
    check_counts("ramp_th50", 6, 1);
    bus.thresh = 8'h51;
    send_frame();
    drain();
    check_counts("ramp_th51", 6, 1);
    bus.mode_thresh = 1'b0;
    bus.thresh      = 8'h00;

    // 4: step with random backpressure and input gaps
    rand_rdy = 1'b1;
    gap_pct  = 30;
    fill_step();
    send_frame();
    drain();
    check_counts("stall", 6, 1);
    rand_rdy = 1'b0;
    gap_pct  = 0;
    @(posedge clk);
    #1;

    // 5: random frame followed immediately by its inverse
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'($urandom_range(0, 255));
    send_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = ~img[r][c];
    send_frame();
    drain();
    check_counts("b2b", 12, 2);

    // 6: reset after 9 beats, then a clean constant frame
    fill_const(8'h33);
    for (int i = 0; i < 9; i++) send_pixel(i / W, i % W);
    check("pre_rst_pending", exp_q.size(), 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_m_valid", bus.m_valid, 0);
      check("mid_rst_s_ready", bus.s_ready, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame();
    drain();
    check_counts("after_rst", 6, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
